// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode and phase definitions for the Simple RISC CPU controller
package cpu_pkg;

    localparam int OPCODE_WIDTH = 3;
    localparam int PHASE_WIDTH  = 3;

    typedef enum logic [OPCODE_WIDTH-1:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_t;

    typedef enum logic [PHASE_WIDTH-1:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_t;

    // Opcodes that read an operand and load the accumulator
    function automatic logic is_aluop(input logic [OPCODE_WIDTH-1:0] op);
        return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    endfunction

endpackage

// File: rtl/cpu_phase_counter.sv
// rtl/cpu_phase_counter.sv - wrapping phase counter with synchronous reset and hold
module cpu_phase_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (!hold) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/cpu_controller.sv
// rtl/cpu_controller.sv - 8-phase instruction sequencer; CPU_CTRL_STEP_EN adds single-step input
module cpu_controller #(
    parameter int OPCODE_WIDTH = cpu_pkg::OPCODE_WIDTH,
    parameter int PHASE_WIDTH  = cpu_pkg::PHASE_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic                    zero,
    output logic                    sel,
    output logic                    rd,
    output logic                    wr,
    output logic                    ld_ir,
    output logic                    ld_ac,
    output logic                    ld_pc,
    output logic                    inc_pc,
    output logic                    data_e,
    output logic                    halt,
    output logic [PHASE_WIDTH-1:0]  phase
`ifdef CPU_CTRL_STEP_EN
    ,
    input  logic                    step
`endif
);

    import cpu_pkg::*;

    logic                   halted;
    logic                   halt_now;
    logic                   step_wait;
    logic                   hold;
    logic                   aluop;
    logic [PHASE_WIDTH-1:0] count;
    phase_t                 cur;

    assign cur      = phase_t'(count);
    assign aluop    = is_aluop(opcode);
    assign halt_now = (cur == OP_ADDR) && (opcode == HLT);

`ifdef CPU_CTRL_STEP_EN
    assign step_wait = (cur == INST_ADDR) && !step;
`else
    assign step_wait = 1'b0;
`endif

    // Freezing at OP_ADDR on the halting edge keeps the phase parked at 4
    assign hold = halted || halt_now || step_wait;

    cpu_phase_counter #(
        .WIDTH (PHASE_WIDTH)
    ) u_phase_counter (
        .clk   (clk),
        .rst   (rst),
        .hold  (hold),
        .count (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            halted <= 1'b0;
        end else if (halt_now) begin
            halted <= 1'b1;
        end
    end

    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        wr     = 1'b0;
        ld_ir  = 1'b0;
        ld_ac  = 1'b0;
        ld_pc  = 1'b0;
        inc_pc = 1'b0;
        data_e = 1'b0;
        halt   = 1'b0;
        if (halted) begin
            halt = 1'b1;
        end else begin
            unique case (cur)
                INST_ADDR: begin
                    sel = 1'b1;
                end
                INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                OP_ADDR: begin
                    inc_pc = 1'b1;
                    halt   = (opcode == HLT);
                end
                OP_FETCH: begin
                    rd = aluop;
                end
                ALU_OP: begin
                    rd     = aluop;
                    inc_pc = (opcode == SKZ) && zero;
                    ld_pc  = (opcode == JMP);
                    data_e = (opcode == STO);
                end
                STORE: begin
                    rd     = aluop;
                    ld_ac  = aluop;
                    ld_pc  = (opcode == JMP);
                    wr     = (opcode == STO);
                    data_e = (opcode == STO);
                end
                default: begin
                    sel = 1'b1;
                end
            endcase
        end
    end

    assign phase = count;

endmodule
